// File: rtl/program_loader.sv
// Program store and run sequencer: loads a program over valid/ready, then runs
// the core until its PC leaves the loaded range.
package program_loader_pkg;
  typedef logic [31:0] instruction_t;
  typedef logic [15:0] pc_t;
endpackage

module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [$bits(instruction_t)-1:0] load_data,
  input  logic                       load_last,
  input  pc_t                        program_counter,
  output instruction_t               instruction,
  output logic                       core_rst,
  output logic [AW:0]                prog_len,
  output logic                       halted,
  output logic [31:0]                cycle_count
);

  // state | meaning
  // IDLE  | after reset, core held in reset, nothing loaded
  // LOAD  | accepting program words into the store
  // RUN   | core released, serving instructions
  // HALT  | PC left the program, core back in reset
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  localparam int CW = ($bits(pc_t) > AW + 1) ? $bits(pc_t) : AW + 1;

  state_t       state_q, state_d;
  logic [AW:0]  prog_len_q, prog_len_d;
  logic [31:0]  cycle_count_q, cycle_count_d;
  logic         load_ready_q, load_ready_d;
  logic         core_rst_q, core_rst_d;
  logic         halted_q, halted_d;

  instruction_t mem [DEPTH];

  logic handshake;
  logic pc_in_range;

  assign handshake   = (state_q == LOAD) && load_valid && load_ready_q;
  assign pc_in_range = CW'(program_counter) < CW'(prog_len_q);

  // The write pointer always equals the running word count, so prog_len doubles as wptr.
  always_comb begin
    state_d       = state_q;
    prog_len_d    = prog_len_q;
    cycle_count_d = cycle_count_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d    = LOAD;
          prog_len_d = '0;
        end
      end
      LOAD: begin
        if (handshake) begin
          prog_len_d = prog_len_q + 1'b1;
          if (load_last || prog_len_q == (AW+1)'(DEPTH - 1)) begin
            state_d       = RUN;
            cycle_count_d = '0;
          end
        end
      end
      RUN: begin
        if (~&cycle_count_q) cycle_count_d = cycle_count_q + 32'd1;
        if (!pc_in_range) state_d = HALT;
      end
    endcase
    load_ready_d = (state_d == LOAD) && (prog_len_d < (AW+1)'(DEPTH));
    core_rst_d   = (state_d == RUN);
    halted_d     = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      prog_len_q    <= '0;
      cycle_count_q <= '0;
      load_ready_q  <= 1'b0;
      core_rst_q    <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      prog_len_q    <= prog_len_d;
      cycle_count_q <= cycle_count_d;
      load_ready_q  <= load_ready_d;
      core_rst_q    <= core_rst_d;
      halted_q      <= halted_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && handshake) mem[prog_len_q[AW-1:0]] <= load_data;
  end

  assign instruction = pc_in_range ? mem[program_counter[AW-1:0]] : '0;
  assign load_ready  = load_ready_q;
  assign core_rst    = core_rst_q;
  assign prog_len    = prog_len_q;
  assign halted      = halted_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: fixed load table, hand-written corner sequences and
// randomized load/run sessions checked against a word-list model of the program.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic         clk = 1'b0;
  logic         rst, start, load_valid, load_last, load_ready;
  instruction_t load_data, instruction;
  pc_t          program_counter;
  logic         core_rst, halted;
  logic [AW:0]  prog_len;
  logic [31:0]  cycle_count;

  int vectors = 0;
  int miscompares = 0;

  instruction_t model_mem [DEPTH];
  int           model_len = 0;
  int           model_cycles = 0;

  typedef struct {
    logic         valid;
    instruction_t data;
    logic         last;
    logic [AW:0]  exp_len;
    logic         exp_core_rst;
  } vec_t;
  vec_t tbl [7];

  program_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last),
    .program_counter(program_counter), .instruction(instruction),
    .core_rst(core_rst), .prog_len(prog_len), .halted(halted),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic instruction_t exp_instr(input pc_t pc);
    int p;
    p = int'(pc);
    return (p < model_len) ? model_mem[p] : '0;
  endfunction

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    model_len = 0;
    check("start_ready", load_ready, 1);
    check("start_len", prog_len, 0);
    check("start_halted", halted, 0);
    check("start_core_rst", core_rst, 0);
    check("start_cycles_frozen", cycle_count, model_cycles);
  endtask

  task automatic do_load(input int n, input bit with_last, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++) begin
        load_valid = 1'b0;
        load_last  = 1'($urandom_range(1));
        load_data  = $urandom;
        start      = 1'($urandom_range(1));
        #1;
        check("gap_ready", load_ready, 1);
        step();
        check("gap_len", prog_len, i);
      end
      load_valid = 1'b1;
      load_data  = $urandom;
      load_last  = with_last && (i == n - 1);
      start      = 1'($urandom_range(1));
      #1;
      check("load_ready", load_ready, 1);
      model_mem[i] = load_data;
      step();
      check("load_len", prog_len, i + 1);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    start      = 1'b0;
    model_len    = n;
    model_cycles = 0;
    check("run_core_rst", core_rst, 1);
    check("run_ready_low", load_ready, 0);
    check("run_cycles_zero", cycle_count, 0);
  endtask

  task automatic run_pc(input pc_t pc);
    bit out_of_range;
    out_of_range = int'(pc) >= model_len;
    program_counter = pc;
    #1;
    check("instruction", instruction, exp_instr(pc));
    step();
    model_cycles++;
    check("cycle_count", cycle_count, model_cycles);
    check("halted", halted, out_of_range);
    check("core_rst", core_rst, !out_of_range);
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h11, 1'b0, 9'd1, 1'b0};
    tbl[1] = '{1'b0, 32'hDEAD, 1'b0, 9'd1, 1'b0};
    tbl[2] = '{1'b1, 32'h22, 1'b0, 9'd2, 1'b0};
    tbl[3] = '{1'b0, 32'hBEEF, 1'b1, 9'd2, 1'b0};
    tbl[4] = '{1'b1, 32'h33, 1'b0, 9'd3, 1'b0};
    tbl[5] = '{1'b0, 32'h0, 1'b0, 9'd3, 1'b0};
    tbl[6] = '{1'b1, 32'h44, 1'b1, 9'd4, 1'b1};

    rst = 1'b0; start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; program_counter = '0;
    step();
    step();
    check("rst_ready", load_ready, 0);
    check("rst_core_rst", core_rst, 0);
    check("rst_halted", halted, 0);
    check("rst_len", prog_len, 0);
    check("rst_cycles", cycle_count, 0);
    rst = 1'b1;
    step();
    check("idle_ready", load_ready, 0);

    // Table-driven 4-word load with valid toggling
    do_start();
    for (int i = 0; i < 7; i++) begin
      load_valid = tbl[i].valid;
      load_data  = tbl[i].data;
      load_last  = tbl[i].last;
      #1;
      check("tbl_ready", load_ready, 1);
      if (tbl[i].valid) model_mem[int'(tbl[i].exp_len) - 1] = tbl[i].data;
      step();
      check("tbl_len", prog_len, tbl[i].exp_len);
      check("tbl_core_rst", core_rst, tbl[i].exp_core_rst);
    end
    load_valid = 1'b0; load_last = 1'b0;
    model_len = 4; model_cycles = 0;
    check("tbl_cycles_zero", cycle_count, 0);
    for (int p = 0; p <= 4; p++) run_pc(pc_t'(p));
    check("halt_cycles_5", cycle_count, 5);
    program_counter = pc_t'(2);
    #1;
    check("pc2_0x33_after_halt", instruction, 32'h33);

    // Reload from HALT with a 2-word program; stale mem[3] must be unreachable
    do_start();
    do_load(2, 1'b1, 0);
    run_pc(pc_t'(1));
    run_pc(pc_t'(3));

    // Reset in the middle of a load
    do_start();
    load_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load_data = $urandom;
      step();
    end
    load_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    model_len = 0; model_cycles = 0;
    check("mid_rst_len", prog_len, 0);
    check("mid_rst_core_rst", core_rst, 0);
    check("mid_rst_ready", load_ready, 0);
    rst = 1'b0; start = 1'b1;
    step();
    rst = 1'b1; start = 1'b0;
    check("rst_beats_start", load_ready, 0);
    do_start();
    do_load(1, 1'b1, 50);
    run_pc(pc_t'(0));
    run_pc(pc_t'(1));

    // Fill the whole store without load_last; PC with bit AW set is out of range
    do_start();
    do_load(DEPTH, 1'b0, 0);
    check("full_len", prog_len, DEPTH);
    run_pc(pc_t'(DEPTH - 1));
    run_pc(pc_t'(0));
    run_pc(pc_t'($urandom_range(DEPTH - 1)));
    run_pc(pc_t'(DEPTH));
    check("full_ready_after", load_ready, 0);

    // Randomized sessions
    for (int s = 0; s < 12; s++) begin
      int n;
      do_start();
      n = $urandom_range(1, 24);
      do_load(n, 1'b1, 30);
      repeat ($urandom_range(1, 10)) run_pc(pc_t'($urandom_range(n - 1)));
      run_pc(pc_t'($urandom_range(n, 65535)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Program memory and run sequencer upstream of the processor top. Accepts a program over a valid/ready load stream into an internal instruction store, then releases the processor from reset and serves `instruction` combinationally for the `program_counter` the core presents. Execution stops when the PC leaves the loaded range: the core is returned to reset and `halted` is raised.

## Interface
- `DEPTH`, 256, instruction-store depth in words; must be a power of 2 and ≤ 2^$bits(pc_t).
- `AW`, $clog2(DEPTH), store address width (derived; do not override).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a load session (honoured only in IDLE or HALT).
- `load_valid`  in  1  load word valid.
- `load_ready`  out  1  loader can accept a word.
- `load_data`  in  $bits(instruction_t)  instruction word (type instruction_t).
- `load_last`  in  1  marks the final word of the program.
- `program_counter`  in  pc_t  PC driven by the core.
- `instruction`  out  instruction_t  word fed to the core.
- `core_rst`  out  1  active-low synchronous reset to the core.
- `prog_len`  out  AW+1  number of words loaded in the last session.
- `halted`  out  1  high in HALT.
- `cycle_count`  out  32  core cycles executed in the current or last run; saturates at 2^32-1.

## Operation
- States: IDLE, LOAD, RUN, HALT. Reset forces IDLE.
- IDLE: `load_ready`=0, `core_rst`=0. `start` → LOAD, `prog_len` cleared to 0, write pointer cleared to 0.
- LOAD: `load_ready`=1 while the write pointer < DEPTH. A handshake (`load_valid` & `load_ready`) writes `load_data` to mem[wptr], increments `wptr` and `prog_len`.
  - A handshake carrying `load_last`, or the handshake that fills word DEPTH-1, → RUN next cycle.
  - `start` in LOAD is ignored.
- RUN: `core_rst`=1. `cycle_count` increments each cycle in RUN (saturating).
  - If `program_counter` ≥ `prog_len` → HALT; the out-of-range PC is sampled in the same cycle.
- HALT: `core_rst`=0, `halted`=1, `cycle_count` frozen. `start` → LOAD; memory contents beyond the new program are left stale but unreachable.
- `instruction` = mem[program_counter[AW-1:0]] when `program_counter` < `prog_len`, otherwise all-zeros. Read is combinational and independent of state.
- PC bits above AW are non-zero → treated as out of range.
- Empty program: not possible. A session ends only on a handshake, so `prog_len` ≥ 1.

## Timing
- Reset values: `load_ready`=0, `core_rst`=0, `halted`=0, `prog_len`=0, `cycle_count`=0, state IDLE. Memory contents are not reset.
- `start` at edge N → LOAD at N+1; `load_ready`=1 during cycle N+1.
- Final handshake at edge M → state RUN and `core_rst`=1 from M+1. The core's first active edge is M+2, at which it executes mem[0].
- `cycle_count` at RUN entry is 0 and increments on every edge spent in RUN.
- PC out of range sampled at edge K → HALT with `core_rst`=0 from K+1. The zero word is what is presented during cycle K.
- `load_ready` depends only on state and `wptr` (registered), never on `load_valid`.
- Reset asserted mid-LOAD or mid-RUN → IDLE next edge. The partial program is discarded: `prog_len`=0.
- `start` coincident with reset → reset wins.

## Test plan
- Reset, then `start`; stream 4 words 0x11, 0x22, 0x33, 0x44 (`load_last` on 0x44) with `load_valid` held high → `prog_len`=4, `core_rst` rises 1 cycle after the last handshake, `instruction`=0x33 for PC=2.
- Same load with `load_valid` toggling 1,0,1,0… → identical memory contents; `load_ready` stays 1 throughout LOAD.
- RUN with PC stepping 0,1,2,3,4 → HALT entered the edge after PC=4 is sampled, `instruction`=0 at PC=4, `halted`=1, `cycle_count`=5.
- Load DEPTH words with no `load_last` → RUN after word DEPTH-1, `prog_len`=DEPTH, `load_ready`=0 from then on.
- Reset low for 1 cycle after 2 of 4 words in LOAD → IDLE, `prog_len`=0, `core_rst`=0; a subsequent `start` and 1-word load runs correctly.
- From HALT, `start` plus a 2-word program → `halted` clears, `cycle_count` resets to 0 at RUN entry, PC=3 yields `instruction`=0.
